ewb_drain_arbiter: RTL and testbench

- Memory-side consumer of the eviction write buffer (EWB).
- Sits between the cache miss path, the EWB outputs and the cacheline adapter / physical memory port.
- Arbitrates cache line fills (reads) against EWB writebacks (drains), with reads prioritised.
- Forwards a fill directly from the EWB when the miss address matches the buffered dirty line.
- Bounds writeback starvation with a bypass counter.

---
 rtl/ewb_drain_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ewb_drain_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ewb_drain_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ewb_drain_arbiter
//  Brief    : Memory-side arbiter between cache line fills and eviction
//             write buffer drains. Fills take priority. A fill that hits the
//             buffered dirty line is forwarded without a memory access. A
//             bypass counter bounds how long a writeback can be starved.
//  Revision : 1.0 - initial release
// ============================================================================
module ewb_drain_arbiter #(
   parameter int OFFSET_BITS = 4,
   parameter int MAX_BYPASS  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ewb_valid,
   input  logic [31:0]  ewb_addr,
   input  logic [127:0] ewb_data,
   output logic         ewb_clear,
   input  logic         fill_read,
   input  logic [31:0]  fill_addr,
   output logic [127:0] fill_rdata,
   output logic         fill_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
);

   localparam int                 c_cnt_w   = $clog2(MAX_BYPASS + 1);
   localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_BYPASS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_DRAIN = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [c_cnt_w-1:0]   r_bypass_cnt;
   logic                 r_suppress;
   logic                 r_pmem_read;
   logic                 r_pmem_write;
   logic [31:0]          r_pmem_address;
   logic [127:0]         r_pmem_wdata;
   logic [127:0]         r_fill_rdata;

   logic                 w_ewb_live;
   logic                 w_line_match;
   logic                 w_forward;
   logic                 w_bypass_inc;
   logic [31:0]          w_fill_line;
   logic [31:0]          w_ewb_line;
   logic                 w_unused_offsets;

   // A buffered line is only eligible when it is not the stale copy of a
   // line that was drained on the previous cycle.
   assign w_ewb_live       = ewb_valid && !r_suppress;
   assign w_line_match     = (fill_addr[31:OFFSET_BITS] == ewb_addr[31:OFFSET_BITS]);
   assign w_fill_line      = {fill_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign w_ewb_line       = {ewb_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
   assign w_unused_offsets = ^{fill_addr[OFFSET_BITS-1:0], ewb_addr[OFFSET_BITS-1:0]};

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state selection: forward hit, forced drain, fill, drain, idle.
   always_comb begin
      w_next_state = r_state;
      w_forward    = 1'b0;
      w_bypass_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (fill_read && w_ewb_live && w_line_match) begin
               w_next_state = S_RESP;
               w_forward    = 1'b1;
            end else if (w_ewb_live && (r_bypass_cnt == c_max_cnt)) begin
               w_next_state = S_DRAIN;
            end else if (fill_read) begin
               w_next_state = S_FILL;
               w_bypass_inc = w_ewb_live;
            end else if (w_ewb_live) begin
               w_next_state = S_DRAIN;
            end
         end
         S_FILL: begin
            if (pmem_resp) begin
               w_next_state = S_RESP;
            end
         end
         S_DRAIN: begin
            if (pmem_resp) begin
               w_next_state = S_IDLE;
            end
         end
         S_RESP: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Memory request registers and fill data capture; requests are loaded on
   // entry to FILL/DRAIN, held, and dropped on the completing edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
         r_pmem_address <= 32'd0;
         r_pmem_wdata   <= 128'd0;
         r_fill_rdata   <= 128'd0;
         r_suppress     <= 1'b0;
      end else begin
         r_suppress <= (r_state == S_DRAIN) && pmem_resp;
         case (r_state)
            S_IDLE: begin
               if (w_forward) begin
                  r_fill_rdata <= ewb_data;
               end else if (w_next_state == S_DRAIN) begin
                  r_pmem_write   <= 1'b1;
                  r_pmem_address <= w_ewb_line;
                  r_pmem_wdata   <= ewb_data;
               end else if (w_next_state == S_FILL) begin
                  r_pmem_read    <= 1'b1;
                  r_pmem_address <= w_fill_line;
               end
            end
            S_FILL: begin
               if (pmem_resp) begin
                  r_pmem_read    <= 1'b0;
                  r_pmem_address <= 32'd0;
                  r_fill_rdata   <= pmem_rdata;
               end
            end
            S_DRAIN: begin
               if (pmem_resp) begin
                  r_pmem_write   <= 1'b0;
                  r_pmem_address <= 32'd0;
                  r_pmem_wdata   <= 128'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Bypass counter: counts fills that overtake a live drain, saturating at
   // the limit; cleared when the buffer empties or a drain starts.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_bypass_cnt <= '0;
      end else if (!ewb_valid) begin
         r_bypass_cnt <= '0;
      end else if ((r_state == S_IDLE) && (w_next_state == S_DRAIN)) begin
         r_bypass_cnt <= '0;
      end else if (w_bypass_inc && (r_bypass_cnt < c_max_cnt)) begin
         r_bypass_cnt <= r_bypass_cnt + 1'b1;
      end
   end

   assign pmem_read    = r_pmem_read;
   assign pmem_write   = r_pmem_write;
   assign pmem_address = r_pmem_address;
   assign pmem_wdata   = r_pmem_wdata;
   assign fill_rdata   = r_fill_rdata;
   assign fill_resp    = (r_state == S_RESP);
   // Gated by reset so a drain abandoned by reset can never report completion.
   assign ewb_clear    = rst && (r_state == S_DRAIN) && pmem_resp;

endmodule
`default_nettype wire

// File: tb/tb_ewb_drain_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ewb_drain_arbiter
//  Brief    : Scoreboard bench for ewb_drain_arbiter. Expected memory
//             requests, fill responses and buffer clears are queued as
//             stimulus is applied and compared as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ewb_drain_arbiter;

   localparam int MAX_BYPASS = 4;
   localparam int K_NONE = 0;
   localparam int K_RD   = 1;
   localparam int K_WR   = 2;
   localparam int K_RESP = 3;
   localparam int K_CLR  = 4;

   typedef struct {
      int           kind;
      logic [31:0]  addr;
      logic [127:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   wr_cycles = 0;
   int   clr_cnt = 0;
   int   mem_lat = 2;
   bit   mem_en = 1'b1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         ewb_valid = 1'b0;
   logic [31:0]  ewb_addr = 32'd0;
   logic [127:0] ewb_data = 128'd0;
   logic         ewb_clear;
   logic         fill_read = 1'b0;
   logic [31:0]  fill_addr = 32'd0;
   logic [127:0] fill_rdata;
   logic         fill_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata = 128'd0;
   logic         pmem_resp = 1'b0;

   logic         prev_read = 1'b0;
   logic         prev_write = 1'b0;
   logic [31:0]  prev_addr = 32'd0;
   logic [127:0] prev_wdata = 128'd0;

   ewb_drain_arbiter #(
      .OFFSET_BITS (4),
      .MAX_BYPASS  (MAX_BYPASS)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .ewb_valid    (ewb_valid),
      .ewb_addr     (ewb_addr),
      .ewb_data     (ewb_data),
      .ewb_clear    (ewb_clear),
      .fill_read    (fill_read),
      .fill_addr    (fill_addr),
      .fill_rdata   (fill_rdata),
      .fill_resp    (fill_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] mem_word(input logic [31:0] a);
      return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h1234_5678};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [127:0] d);
      exp_t e;
      e.kind = kind;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic pop_check(input int kind, input logic [31:0] a, input logic [127:0] d);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_unexpected_event", kind, K_NONE);
      end else begin
         e = sb.pop_front();
         check("ev_kind", kind, e.kind);
         if (e.kind == kind) begin
            if (kind == K_RD || kind == K_WR) check("ev_addr", a, e.addr);
            if (kind == K_WR || kind == K_RESP) check("ev_data", d, e.data);
         end
      end
   endtask

   task automatic fill_wait(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fill_resp) begin
            seen = 1'b1;
            fill_read = 1'b0;
            break;
         end
      end
      check(tag, seen, 1'b1);
   endtask

   task automatic wait_ewb_idle(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!ewb_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, seen, 1'b1);
   endtask

   // Memory model: completes any held request after mem_lat cycles.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_en) begin
            pmem_resp = 1'b0;
            if (pmem_read || pmem_write) begin
               cnt++;
               if (cnt >= mem_lat) begin
                  pmem_resp  = 1'b1;
                  pmem_rdata = mem_word(pmem_address);
                  cnt = 0;
               end
            end else begin
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Buffer model: after a clear the stale valid lingers one extra cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (ewb_clear) begin
            @(posedge clk);
            @(posedge clk);
            #1;
            ewb_valid = 1'b0;
         end
      end
   end

   // Monitor: protocol checks and scoreboard comparison of DUT events.
   initial begin
      forever begin
         @(negedge clk);
         if (pmem_read || pmem_write) check("rw_exclusive", pmem_read & pmem_write, 1'b0);
         if (pmem_read && prev_read) check("rd_addr_hold", pmem_address, prev_addr);
         if (pmem_write && prev_write) begin
            check("wr_addr_hold", pmem_address, prev_addr);
            check("wr_data_hold", pmem_wdata, prev_wdata);
         end
         if (pmem_read && !prev_read) pop_check(K_RD, pmem_address, 128'd0);
         if (pmem_write && !prev_write) pop_check(K_WR, pmem_address, pmem_wdata);
         if (fill_resp) pop_check(K_RESP, 32'd0, fill_rdata);
         if (ewb_clear) begin
            pop_check(K_CLR, 32'd0, 128'd0);
            clr_cnt++;
         end
         if (pmem_write) wr_cycles++;
         prev_read  = pmem_read;
         prev_write = pmem_write;
         prev_addr  = pmem_address;
         prev_wdata = pmem_wdata;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Stimulus.
   initial begin
      int           wr_start;
      int           clr_start;
      bit           seen;
      logic [31:0]  a;
      logic [127:0] d;

      // Reset with a fill already requested.
      rst       = 1'b0;
      fill_read = 1'b1;
      fill_addr = 32'h0000_123C;
      mem_lat   = 2;
      repeat (2) begin
         @(negedge clk);
         check("rst_ctl", {pmem_read, pmem_write, ewb_clear, fill_resp}, 4'b0000);
         check("rst_addr", pmem_address, 32'd0);
         check("rst_wdata", pmem_wdata, 128'd0);
         check("rst_rdata", fill_rdata, 128'd0);
      end
      push(K_RD, 32'h0000_1230, 128'd0);
      push(K_RESP, 32'd0, mem_word(32'h0000_1230));
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("t1_no_early_rd", pmem_read, 1'b0);
      @(negedge clk);
      check("t1_rd_latency", pmem_read, 1'b1);
      check("t1_rd_addr", pmem_address, 32'h0000_1230);
      fill_wait("t1_fill_timeout");
      repeat (2) @(posedge clk);

      // Forward from the buffer on a line match.
      d = {4{32'hDEAD_BEEF}};
      push(K_RESP, 32'd0, d);
      @(posedge clk);
      #1;
      ewb_valid = 1'b1;
      ewb_addr  = 32'h8000_0040;
      ewb_data  = d;
      fill_addr = 32'h8000_004C;
      fill_read = 1'b1;
      @(negedge clk);
      check("t2_no_early_resp", fill_resp, 1'b0);
      @(negedge clk);
      check("t2_fwd_latency", fill_resp, 1'b1);
      check("t2_fwd_data", fill_rdata, d);
      check("t2_no_mem", {pmem_read, pmem_write}, 2'b00);
      fill_read = 1'b0;
      ewb_valid = 1'b0;
      repeat (3) @(posedge clk);

      // Drain only, slow memory, stale valid held one extra cycle.
      mem_lat = 5;
      d = 128'h0303_0303_A5A5_A5A5_1111_2222_3333_4444;
      push(K_WR, 32'h0000_2000, d);
      push(K_CLR, 32'd0, 128'd0);
      wr_start  = wr_cycles;
      clr_start = clr_cnt;
      @(posedge clk);
      #1;
      ewb_addr  = 32'h0000_2000;
      ewb_data  = d;
      ewb_valid = 1'b1;
      wait_ewb_idle("t3_drain_timeout");
      repeat (3) @(posedge clk);
      check("t3_wr_cycles", wr_cycles - wr_start, 5);
      check("t3_clr_pulses", clr_cnt - clr_start, 1);

      // Read priority over a non-matching drain.
      mem_lat = 2;
      d = 128'h0404_0404_0404_0404_CAFE_F00D_0000_0004;
      push(K_RD, 32'h0000_5550, 128'd0);
      push(K_RESP, 32'd0, mem_word(32'h0000_5550));
      push(K_WR, 32'h4000_0000, d);
      push(K_CLR, 32'd0, 128'd0);
      @(posedge clk);
      #1;
      ewb_addr  = 32'h4000_0000;
      ewb_data  = d;
      ewb_valid = 1'b1;
      fill_addr = 32'h0000_5554;
      fill_read = 1'b1;
      fill_wait("t4_fill_timeout");
      wait_ewb_idle("t4_drain_timeout");
      repeat (2) @(posedge clk);

      // Starvation bound: MAX_BYPASS fills, forced drain, fills resume.
      d = 128'h0505_0505_0505_0505_0505_0505_0505_0505;
      for (int k = 0; k < 6; k++) begin
         a = 32'h0001_0000 + 32'(k) * 32'h100;
         if (k == MAX_BYPASS) begin
            push(K_WR, 32'h7000_0000, d);
            push(K_CLR, 32'd0, 128'd0);
         end
         push(K_RD, a, 128'd0);
         push(K_RESP, 32'd0, mem_word(a));
      end
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            ewb_addr  = 32'h7000_0004;
            ewb_data  = d;
            ewb_valid = 1'b1;
         end
         fill_addr = 32'h0001_0000 + 32'(k) * 32'h100 + 32'h4;
         fill_read = 1'b1;
         fill_wait("t5_fill_timeout");
      end
      wait_ewb_idle("t5_drain_timeout");
      repeat (2) @(posedge clk);

      // Reset in the middle of a drain; a late completion is ignored.
      mem_en    = 1'b0;
      clr_start = clr_cnt;
      d = 128'h0606_0606_0606_0606_0606_0606_0606_0606;
      push(K_WR, 32'h9000_0000, d);
      @(posedge clk);
      #1;
      ewb_addr  = 32'h9000_0000;
      ewb_data  = d;
      ewb_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pmem_write) begin
            seen = 1'b1;
            break;
         end
      end
      check("t6_drain_start", seen, 1'b1);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      ewb_valid = 1'b0;
      @(negedge clk);
      check("t6_clr_in_rst", ewb_clear, 1'b0);
      @(negedge clk);
      check("t6_wr_dropped", pmem_write, 1'b0);
      check("t6_clr_after_rst", ewb_clear, 1'b0);
      @(posedge clk);
      #1;
      rst        = 1'b1;
      pmem_resp  = 1'b1;
      pmem_rdata = {4{32'hFFFF_0000}};
      @(negedge clk);
      check("t6_late_resp_clr", ewb_clear, 1'b0);
      @(posedge clk);
      #1 pmem_resp = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t6_idle_outs", {pmem_read, pmem_write, fill_resp, ewb_clear}, 4'b0000);
      end
      check("t6_no_clear", clr_cnt - clr_start, 0);
      mem_en = 1'b1;

      repeat (2) @(posedge clk);
      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
